// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: conditions the writeback fields, carries them through
// DEPTH register stages with stall/flush, exposes a forwarding lookup over the
// in-flight stages and counts retired instructions.
//
// Handshake: valid-only, with no ready. valid_i qualifies the input on every
// rising edge where stall_i is low. valid_o marks the last stage as a real
// instruction. A bubble (valid_i=0) is stored with all fields zero, so a
// bubble can never drive a write or a forwarding hit.
module mem_wb_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic                  reg_write_i,
    input  logic                  mem_to_reg_i,
    input  logic [DATA_W-1:0]     read_data_i,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic [REG_ADDR_W-1:0] write_reg_i,
    input  logic [REG_ADDR_W-1:0] query_reg_i,
    output logic                  valid_o,
    output logic                  reg_write_o,
    output logic [REG_ADDR_W-1:0] write_reg_o,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic                  fwd_hit_o,
    output logic [DATA_W-1:0]     fwd_data_o,
    output logic [CNT_W-1:0]      retired_o
);

    // Index 0 is stage 1 (youngest), index DEPTH-1 drives the outputs.
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      wr_q, wr_d;
    logic [REG_ADDR_W-1:0] reg_q  [DEPTH];
    logic [REG_ADDR_W-1:0] reg_d  [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];
    logic [DATA_W-1:0]     data_d [DEPTH];
    logic [CNT_W-1:0]      retired_q, retired_d;

    logic                  in_wr;
    logic [REG_ADDR_W-1:0] in_reg;
    logic [DATA_W-1:0]     in_data;

    // Condition the incoming entry: resolve MemToReg, drop writes to $zero,
    // and zero every field of a bubble.
    always_comb begin
        in_wr   = reg_write_i & valid_i & (write_reg_i != '0);
        in_reg  = '0;
        in_data = '0;
        if (valid_i) begin
            in_reg  = write_reg_i;
            in_data = mem_to_reg_i ? read_data_i : alu_result_i;
        end
    end

    // Next stage contents: flush clears, stall holds, otherwise shift by one.
    always_comb begin
        valid_d = valid_q;
        wr_d    = wr_q;
        for (int k = 0; k < DEPTH; k++) begin
            reg_d[k]  = reg_q[k];
            data_d[k] = data_q[k];
        end
        if (flush_i) begin
            valid_d = '0;
            wr_d    = '0;
            for (int k = 0; k < DEPTH; k++) begin
                reg_d[k]  = '0;
                data_d[k] = '0;
            end
        end else if (!stall_i) begin
            valid_d[0] = valid_i;
            wr_d[0]    = in_wr;
            reg_d[0]   = in_reg;
            data_d[0]  = in_data;
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                wr_d[k]    = wr_q[k-1];
                reg_d[k]   = reg_q[k-1];
                data_d[k]  = data_q[k-1];
            end
        end
    end

    // The last-stage instruction wrote the register file this cycle, so it
    // retires on any unstalled edge, even one that also flushes.
    always_comb begin
        retired_d = retired_q;
        if (valid_q[DEPTH-1] && !stall_i) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // Stage and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            wr_q      <= '0;
            retired_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                reg_q[k]  <= '0;
                data_q[k] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            wr_q      <= wr_d;
            retired_q <= retired_d;
            for (int k = 0; k < DEPTH; k++) begin
                reg_q[k]  <= reg_d[k];
                data_q[k] <= data_d[k];
            end
        end
    end

    // Forwarding lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (valid_q[k] && wr_q[k] && (reg_q[k] == query_reg_i) &&
                (query_reg_i != '0)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_q[k];
            end
        end
    end

    assign valid_o     = valid_q[DEPTH-1];
    assign reg_write_o = wr_q[DEPTH-1];
    assign write_reg_o = reg_q[DEPTH-1];
    assign wb_data_o   = data_q[DEPTH-1];
    assign retired_o   = retired_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: a DEPTH=1/CNT_W=16 and a DEPTH=3/CNT_W=4 instance
// share one stimulus stream. A queue-based pipeline model predicts each
// cycle's outputs; a negedge monitor pops and compares them.
module tb_mem_wb_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, valid_i, reg_write_i, mem_to_reg_i;
  logic [31:0] read_data_i, alu_result_i;
  logic [4:0]  write_reg_i, query_reg_i;

  logic        v1, wr1, hit1, v3, wr3, hit3;
  logic [4:0]  rg1, rg3;
  logic [31:0] wb1, fd1, wb3, fd3;
  logic [15:0] ret1;
  logic [3:0]  ret3;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock/reset block ----------------
  always #5 clk = ~clk;

  mem_wb_pipe #(.DATA_W(32), .REG_ADDR_W(5), .DEPTH(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
    .read_data_i(read_data_i), .alu_result_i(alu_result_i),
    .write_reg_i(write_reg_i), .query_reg_i(query_reg_i),
    .valid_o(v1), .reg_write_o(wr1), .write_reg_o(rg1), .wb_data_o(wb1),
    .fwd_hit_o(hit1), .fwd_data_o(fd1), .retired_o(ret1));

  mem_wb_pipe #(.DATA_W(32), .REG_ADDR_W(5), .DEPTH(3), .CNT_W(4)) u_d3 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
    .read_data_i(read_data_i), .alu_result_i(alu_result_i),
    .write_reg_i(write_reg_i), .query_reg_i(query_reg_i),
    .valid_o(v3), .reg_write_o(wr3), .write_reg_o(rg3), .wb_data_o(wb3),
    .fwd_hit_o(hit3), .fwd_data_o(fd3), .retired_o(ret3));

  // ---------------- reference model ----------------
  typedef struct {
    logic        v;
    logic        wr;
    logic [4:0]  rg;
    logic [31:0] d;
  } entry_t;

  typedef struct packed {
    logic        v;
    logic        wr;
    logic [4:0]  rg;
    logic [31:0] d;
    logic        hit;
    logic [31:0] fd;
    logic [15:0] ret;
  } snap_t;

  localparam int SNAP_W = $bits(snap_t);

  // In-flight instructions per instance, front = youngest.
  entry_t      pipes [2][$];
  int          dep   [2] = '{1, 3};
  int          cw    [2] = '{16, 4};
  int unsigned cnt   [2];

  logic [SNAP_W-1:0] exp_q [2][$];

  function automatic entry_t empty_entry();
    entry_t e;
    e.v = 1'b0; e.wr = 1'b0; e.rg = '0; e.d = '0;
    return e;
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      pipes[d].delete();
      for (int k = 0; k < dep[d]; k++) pipes[d].push_back(empty_entry());
      cnt[d] = 0;
    end
  endfunction

  // What an incoming instruction looks like once it is in the pipe.
  function automatic entry_t incoming();
    entry_t e = empty_entry();
    if (valid_i) begin
      e.v  = 1'b1;
      e.rg = write_reg_i;
      e.d  = mem_to_reg_i ? read_data_i : alu_result_i;
      e.wr = reg_write_i && (write_reg_i != 5'd0);
    end
    return e;
  endfunction

  // Apply one rising edge to the model using the inputs currently held.
  function automatic void model_edge();
    if (!rst_n) begin
      model_clear();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (pipes[d][dep[d]-1].v && !stall_i)
        cnt[d] = (cnt[d] + 1) % (32'd1 << cw[d]);
      if (flush_i) begin
        foreach (pipes[d][k]) pipes[d][k] = empty_entry();
      end else if (!stall_i) begin
        pipes[d].push_front(incoming());
        void'(pipes[d].pop_back());
      end
    end
  endfunction

  // Expected outputs for the current cycle.
  function automatic snap_t predict(int d);
    snap_t  s;
    entry_t last = pipes[d][dep[d]-1];
    s.v = last.v; s.wr = last.wr; s.rg = last.rg; s.d = last.d;
    s.hit = 1'b0; s.fd = '0;
    s.ret = 16'(cnt[d]);
    for (int k = 0; k < dep[d]; k++) begin
      if (pipes[d][k].v && pipes[d][k].wr && pipes[d][k].rg == query_reg_i &&
          query_reg_i != 5'd0) begin
        s.hit = 1'b1;
        s.fd  = pipes[d][k].d;
        break;
      end
    end
    return s;
  endfunction

  // ---------------- scoreboard compare ----------------
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Monitor: one expected snapshot per instance per cycle.
  initial begin
    snap_t s;
    forever begin
      @(negedge clk);
      if (exp_q[0].size() > 0) begin
        s = snap_t'(exp_q[0].pop_front());
        check("d1.valid_o",     32'(v1),   32'(s.v));
        check("d1.reg_write_o", 32'(wr1),  32'(s.wr));
        check("d1.write_reg_o", 32'(rg1),  32'(s.rg));
        check("d1.wb_data_o",   wb1,       s.d);
        check("d1.fwd_hit_o",   32'(hit1), 32'(s.hit));
        check("d1.fwd_data_o",  fd1,       s.fd);
        check("d1.retired_o",   32'(ret1), 32'(s.ret));
      end
      if (exp_q[1].size() > 0) begin
        s = snap_t'(exp_q[1].pop_front());
        check("d3.valid_o",     32'(v3),   32'(s.v));
        check("d3.reg_write_o", 32'(wr3),  32'(s.wr));
        check("d3.write_reg_o", 32'(rg3),  32'(s.rg));
        check("d3.wb_data_o",   wb3,       s.d);
        check("d3.fwd_hit_o",   32'(hit3), 32'(s.hit));
        check("d3.fwd_data_o",  fd3,       s.fd);
        check("d3.retired_o",   32'(ret3), 32'(s.ret));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge: drive inputs, queue this cycle's
  // expectation, then let the next edge happen and update the model.
  task automatic step(input logic v, input logic rw, input logic m2r,
                      input logic [31:0] rd, input logic [31:0] alu,
                      input logic [4:0] wreg, input logic [4:0] q,
                      input logic st, input logic fl);
    valid_i      = v;
    reg_write_i  = rw;
    mem_to_reg_i = m2r;
    read_data_i  = rd;
    alu_result_i = alu;
    write_reg_i  = wreg;
    query_reg_i  = q;
    stall_i      = st;
    flush_i      = fl;
    exp_q[0].push_back(SNAP_W'(predict(0)));
    exp_q[1].push_back(SNAP_W'(predict(1)));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic instr(input logic [4:0] wreg, input logic [31:0] d, input logic [4:0] q);
    step(1'b1, 1'b1, 1'b0, $urandom, d, wreg, q, 1'b0, 1'b0);
  endtask

  task automatic bubble(input logic [4:0] q);
    step(1'b0, 1'b1, 1'b1, $urandom, $urandom, 5'(9), q, 1'b0, 1'b0);
  endtask

  task automatic rand_step();
    step(1'b1 && ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
         $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    valid_i = 0; reg_write_i = 0; mem_to_reg_i = 0; read_data_i = 0;
    alu_result_i = 0; write_reg_i = 0; query_reg_i = 0; stall_i = 0; flush_i = 0;
    model_clear();
    @(posedge clk);
    #1;

    // Reset state held over a couple of edges.
    step(1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 5'd3, 5'd3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 5'd3, 5'd3, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Basic load writeback, then drain.
    step(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h1234, 5'd8, 5'd8, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h1234, 5'd8, 5'd8, 1'b0, 1'b0);
    repeat (3) bubble(5'd8);

    // $zero destination and bubbles.
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h66, 32'h0, 5'd4, 5'd4, 1'b0, 1'b0);
    repeat (3) bubble(5'd9);

    // A, B, two stalled cycles, C, then drain.
    instr(5'd1, 32'hA, 5'd1);
    instr(5'd2, 32'hB, 5'd2);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'hEE, 5'd6, 5'd2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'hEE, 5'd6, 5'd1, 1'b1, 1'b0);
    instr(5'd3, 32'hC, 5'd3);
    repeat (4) bubble(5'd3);

    // Flush together with stall empties everything.
    instr(5'd1, 32'h101, 5'd1);
    instr(5'd2, 32'h102, 5'd1);
    instr(5'd3, 32'h103, 5'd1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h104, 5'd4, 5'd3, 1'b1, 1'b1);
    bubble(5'd3);
    bubble(5'd2);

    // Forwarding: reg 5 in stage 1 (0x11) and stage 3 (0x33).
    instr(5'd5, 32'h33, 5'd5);
    instr(5'd7, 32'h22, 5'd5);
    instr(5'd5, 32'h11, 5'd5);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 1'b1, 1'b0);
    repeat (3) bubble(5'd5);

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 17; i++) instr(5'($urandom_range(1, 31)), $urandom, 5'd0);
    repeat (3) bubble(5'd0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) rand_step();

    // Asynchronous reset between edges with three instructions in flight.
    instr(5'd10, 32'hAAA, 5'd10);
    instr(5'd11, 32'hBBB, 5'd10);
    instr(5'd12, 32'hCCC, 5'd10);
    query_reg_i = 5'd10;
    #2;
    rst_n = 1'b0;
    #1;
    check("async.d1.valid_o",   32'(v1),   32'h0);
    check("async.d1.wb_data_o", wb1,       32'h0);
    check("async.d1.retired_o", 32'(ret1), 32'h0);
    check("async.d3.valid_o",   32'(v3),   32'h0);
    check("async.d3.reg_write", 32'(wr3),  32'h0);
    check("async.d3.write_reg", 32'(rg3),  32'h0);
    check("async.d3.wb_data_o", wb3,       32'h0);
    check("async.d3.fwd_hit_o", 32'(hit3), 32'h0);
    check("async.d3.fwd_data",  fd3,       32'h0);
    check("async.d3.retired_o", 32'(ret3), 32'h0);
    model_clear();
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h77, 5'd7, 5'd7, 1'b0, 1'b0);
    rst_n = 1'b1;
    instr(5'd7, 32'h78, 5'd7);
    for (int i = 0; i < 50; i++) rand_step();
    repeat (4) bubble(5'd0);

    @(negedge clk);
    #1;
    check("scoreboard.drained", 32'(exp_q[0].size() + exp_q[1].size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM/WB pipeline stage for the MIPS datapath, sitting between data memory and the register file write port. It registers the load data, ALU result, destination register and writeback control through DEPTH stages, and resolves the MemToReg selection before writeback. It also supports stall and flush, suppresses writes to $zero, and provides a forwarding lookup for the hazard unit. A retired-instruction counter is included.

## Interface
Parameters:
- DATA_W, 32, width of read data, ALU result and writeback data
- REG_ADDR_W, 5, register index width
- DEPTH, 1, number of register stages (legal range 1..4)
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold all stages
- flush_i  in  1  kill all stage contents
- valid_i  in  1  incoming instruction is real (0 = bubble)
- reg_write_i  in  1  instruction writes the register file
- mem_to_reg_i  in  1  1 selects read_data_i, 0 selects alu_result_i
- read_data_i  in  DATA_W  data memory output
- alu_result_i  in  DATA_W  ALU result carried from EX/MEM
- write_reg_i  in  REG_ADDR_W  destination register index
- query_reg_i  in  REG_ADDR_W  source register index from the hazard unit
- valid_o  out  1  last stage holds a real instruction
- reg_write_o  out  1  register-file write enable
- write_reg_o  out  REG_ADDR_W  destination index from the last stage
- wb_data_o  out  DATA_W  writeback data from the last stage
- fwd_hit_o  out  1  a pending write matches query_reg_i
- fwd_data_o  out  DATA_W  data of the youngest matching stage
- retired_o  out  CNT_W  count of instructions that left the last stage

## Operation
- Each stage holds the fields valid, wr (reg_write), reg, and data.
- Stage 1 input is conditioned before it is captured:
  - data = mem_to_reg_i ? read_data_i : alu_result_i.
  - wr = reg_write_i & valid_i & (write_reg_i != 0).
  - If valid_i = 0, the entry is stored as a bubble with all fields zero.
- Priority at each edge is flush_i, then stall_i, then advance.
  - Flush: every stage is cleared to all-zero. This happens regardless of stall_i.
  - Stall: every stage holds its value. Inputs are ignored.
  - Advance: stage k+1 takes stage k, and stage 1 takes the conditioned input.
- Outputs come from stage DEPTH and are purely registered:
  - valid_o = valid.
  - reg_write_o = wr.
  - write_reg_o = reg.
  - wb_data_o = data.
- reg_write_o stays asserted while stalled. The register file rewrites the same value, which is idempotent.
- Forwarding is combinational over the stage registers:
  - A stage matches when valid & wr & (reg == query_reg_i) & (query_reg_i != 0).
  - fwd_hit_o is the OR of all matches.
  - fwd_data_o is the data of the lowest-numbered (youngest) matching stage, or 0 when there is no hit.
- Retired counter:
  - Increments by 1 at an edge where stage DEPTH is valid and stall_i = 0. Flush does not cancel this, because that instruction already wrote during the cycle.
  - Counts with reg_write = 0 included (e.g. sw).
  - Wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (rst_n low, asynchronous): all stages and the counter go to 0. Outputs are therefore valid_o=0, reg_write_o=0, write_reg_o=0, wb_data_o=0, fwd_hit_o=0, fwd_data_o=0, retired_o=0.
- Release from reset is synchronous to the next rising edge.
- Latency: an instruction presented at edge N appears on the outputs after edge N+DEPTH-1. For DEPTH=1 it is visible right after edge N. Each stalled edge adds one cycle.
- Throughput: one instruction per cycle while not stalled.
- fwd_* reflects the stage contents within the same cycle. There is no added latency and no dependence on the current input.
- Reset asserted mid-stall or mid-flush clears everything immediately. No instruction is retired on the reset edge.
- Simultaneous flush_i and stall_i: flush wins. The counter still increments if stage DEPTH was valid.

## Test plan
- Reset/basic, DEPTH=1: assert rst_n=0 mid-run, then release. Present valid_i=1, reg_write_i=1, mem_to_reg_i=1, read_data_i=0xDEADBEEF, alu_result_i=0x1234, write_reg_i=8 -> one edge later reg_write_o=1, write_reg_o=8, wb_data_o=0xDEADBEEF, retired_o=1 after the following edge.
- $zero suppression and bubbles: write_reg_i=0 with reg_write_i=1 -> reg_write_o=0 and valid_o=1. valid_i=0 -> every output field is 0 and retired_o does not increment.
- Stall/flush, DEPTH=3: issue instructions A, B, C with stall_i high for 2 cycles after B -> C emerges 2 cycles late and the retired_o increments are skipped during the stall. Assert flush_i together with stall_i -> all stages are empty on the next cycle.
- Forwarding, DEPTH=3: stages hold reg 5 (stage1 data=0x11), reg 5 (stage3 data=0x33), and query_reg_i=5 -> fwd_hit_o=1, fwd_data_o=0x11. With query_reg_i=0 -> fwd_hit_o=0, fwd_data_o=0.
- Counter wrap, CNT_W=4: retire 17 valid instructions -> retired_o=1.
- Async reset mid-pipeline: pull rst_n low between edges while 3 instructions are in flight -> all outputs are 0 immediately, without waiting for a clock edge.
